axi4_lite_slave_timer: RTL and testbench

AXI4-Lite responder exposing a 32-bit prescaled timer/compare unit as a third peripheral beside the UART and PWM slaves on the shared peripheral bus. It decodes its own 16-byte address window, answers read and write transactions from the core's AXI master, and drives a compare-match interrupt. Because the bus ORs ready signals and XORs valid signals across slaves, this block drives every handshake output low for addresses outside its window.

---
 rtl/axi4_lite_timer_pkg.sv | 27 ++
 rtl/axi4_lite_slave_timer_core.sv | 60 ++++++
 rtl/axi4_lite_slave_timer.sv | 174 +++++++++++++++++
 tb/tb_axi4_lite_slave_timer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_timer_pkg.sv
// Shared constants for the AXI4-Lite timer slave: register offsets,
// CTRL bit positions, bus FSM encodings and a byte-strobe merge helper.
package axi4_lite_timer_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_COMPARE  = 2'd2;
  localparam logic [1:0] REG_COUNT    = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_AUTO_CLR = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_MATCH    = 3;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_e;

  // Merge write data into an old word, byte lane by byte lane.
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  strb);
    apply_strb = old;
    for (int i = 0; i < 4; i++)
      if (strb[i]) apply_strb[8*i +: 8] = wd[8*i +: 8];
  endfunction

endpackage

// File: rtl/axi4_lite_slave_timer_core.sv
// timer_core: prescaler, 32-bit COUNT, compare and sticky MATCH flag.
// AXI4_LITE_TIMER_IRQ_EN: when defined, irq is a registered MATCH & IRQ_EN;
// otherwise irq is tied low.
module timer_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        auto_clr,
  input  logic        irq_en,
  input  logic [15:0] prescale,
  input  logic [31:0] compare,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        match_clr,
  output logic [31:0] count,
  output logic        match,
  output logic        irq
);

  logic [15:0] psc;
  logic        tick;
  logic        match_now;

  assign tick      = en && (psc == prescale);
  assign match_now = tick && (count == compare);

  // Prescaler runs 0..PRESCALE while enabled, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst)       psc <= '0;
    else if (tick) psc <= '0;
    else if (en)   psc <= psc + 16'd1;
  end

  // COUNT: a bus write beats a tick; auto-clear reloads 0 on a match tick.
  always_ff @(posedge clk) begin
    if (rst)           count <= '0;
    else if (count_we) count <= count_wdata;
    else if (tick)     count <= (match_now && auto_clr) ? 32'd0 : count + 32'd1;
  end

  // Sticky MATCH; a new match takes priority over a write-1-clear.
  always_ff @(posedge clk) begin
    if (rst)            match <= 1'b0;
    else if (match_now) match <= 1'b1;
    else if (match_clr) match <= 1'b0;
  end

`ifdef AXI4_LITE_TIMER_IRQ_EN
  // Level interrupt, one cycle behind MATCH.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= match & irq_en;
  end
`else
  logic unused_irq_en;
  assign unused_irq_en = irq_en;
  assign irq = 1'b0;
`endif

endmodule

// File: rtl/axi4_lite_slave_timer.sv
// AXI4-Lite responder for the prescaled timer/compare unit. Decodes a
// 16-byte window; handshake outputs stay low for addresses outside it.
// AXI4_LITE_TIMER_IRQ_EN: enables CTRL.IRQ_EN and the irq_o output.
module axi4_lite_slave_timer
  import axi4_lite_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h2000_3000
) (
  input  logic        s_axi_aclk_i,
  input  logic        s_axi_rst_i,
  input  logic [31:0] s_axi_araddr_i,
  input  logic        s_axi_arvalid_i,
  output logic        s_axi_arready_o,
  input  logic        s_axi_rready_i,
  output logic        s_axi_rvalid_o,
  output logic [31:0] s_axi_rdata_o,
  input  logic [31:0] s_axi_awaddr_i,
  input  logic        s_axi_awvalid_i,
  output logic        s_axi_awready_o,
  input  logic [31:0] s_axi_wdata_i,
  input  logic [3:0]  s_axi_wstrb_i,
  input  logic        s_axi_wvalid_i,
  output logic        s_axi_wready_o,
  input  logic        s_axi_bready_i,
  output logic        s_axi_bvalid_o,
  output logic        irq_o
);

  logic clk, rst;
  assign clk = s_axi_aclk_i;
  assign rst = s_axi_rst_i;

  r_state_e r_state, r_next;
  w_state_e w_state, w_next;

  logic ar_hit, aw_hit;
  assign ar_hit = (s_axi_araddr_i[31:4] == BASE_ADDR[31:4]);
  assign aw_hit = (s_axi_awaddr_i[31:4] == BASE_ADDR[31:4]);

  logic unused_addr;
  assign unused_addr = ^{s_axi_araddr_i[1:0], s_axi_awaddr_i[1:0]};

  // Register file (timer state itself lives in timer_core)
  logic        en, auto_clr, irq_en_rd;
  logic [15:0] prescale;
  logic [31:0] compare;
  logic [31:0] count;
  logic        match;

  logic       wr_fire;
  logic [1:0] wr_off;
  logic       ctrl_we, count_we, match_clr;
  logic [31:0] rd_val;

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // Read FSM next state: accept on hit, then hold data until rready
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (s_axi_arvalid_i && ar_hit) r_next = R_ADDR;
      R_ADDR:  r_next = R_DATA;
      R_DATA:  if (s_axi_rready_i) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Read FSM outputs
  always_comb begin
    s_axi_arready_o = (r_state == R_ADDR);
    s_axi_rvalid_o  = (r_state == R_DATA);
  end

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Write FSM next state: address and data must arrive together
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (s_axi_awvalid_i && s_axi_wvalid_i && aw_hit) w_next = W_ADDR;
      W_ADDR:  w_next = W_RESP;
      W_RESP:  if (s_axi_bready_i) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    s_axi_awready_o = (w_state == W_ADDR);
    s_axi_wready_o  = (w_state == W_ADDR);
    s_axi_bvalid_o  = (w_state == W_RESP);
  end

  // The write is applied in the accept cycle, while the master still drives it.
  assign wr_fire   = (w_state == W_ADDR);
  assign wr_off    = s_axi_awaddr_i[3:2];
  assign ctrl_we   = wr_fire && (wr_off == REG_CTRL) && s_axi_wstrb_i[0];
  assign count_we  = wr_fire && (wr_off == REG_COUNT);
  assign match_clr = ctrl_we && s_axi_wdata_i[CTRL_MATCH];

  // CTRL, PRESCALE and COMPARE registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      auto_clr <= 1'b0;
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (ctrl_we) begin
        en       <= s_axi_wdata_i[CTRL_EN];
        auto_clr <= s_axi_wdata_i[CTRL_AUTO_CLR];
      end
      if (wr_fire && wr_off == REG_PRESCALE) begin
        if (s_axi_wstrb_i[0]) prescale[7:0]  <= s_axi_wdata_i[7:0];
        if (s_axi_wstrb_i[1]) prescale[15:8] <= s_axi_wdata_i[15:8];
      end
      if (wr_fire && wr_off == REG_COMPARE)
        compare <= apply_strb(compare, s_axi_wdata_i, s_axi_wstrb_i);
    end
  end

`ifdef AXI4_LITE_TIMER_IRQ_EN
  // IRQ_EN bit, present only in the interrupt build
  always_ff @(posedge clk) begin
    if (rst)          irq_en_rd <= 1'b0;
    else if (ctrl_we) irq_en_rd <= s_axi_wdata_i[CTRL_IRQ_EN];
  end
`else
  assign irq_en_rd = 1'b0;
`endif

  timer_core u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .auto_clr    (auto_clr),
    .irq_en      (irq_en_rd),
    .prescale    (prescale),
    .compare     (compare),
    .count_we    (count_we),
    .count_wdata (apply_strb(count, s_axi_wdata_i, s_axi_wstrb_i)),
    .match_clr   (match_clr),
    .count       (count),
    .match       (match),
    .irq         (irq_o)
  );

  // Read-back mux
  always_comb begin
    rd_val = '0;
    case (s_axi_araddr_i[3:2])
      REG_CTRL:     rd_val = {28'd0, match, irq_en_rd, auto_clr, en};
      REG_PRESCALE: rd_val = {16'd0, prescale};
      REG_COMPARE:  rd_val = compare;
      REG_COUNT:    rd_val = count;
      default:      rd_val = '0;
    endcase
  end

  // Read data captured in the arready cycle, held through R_DATA
  always_ff @(posedge clk) begin
    if (rst)                    s_axi_rdata_o <= '0;
    else if (r_state == R_ADDR) s_axi_rdata_o <= rd_val;
  end

endmodule

// File: tb/tb_axi4_lite_slave_timer.sv
// Directed self-checking bench for axi4_lite_slave_timer.
module tb_axi4_lite_slave_timer;

  localparam logic [31:0] BASE = 32'h2000_3000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PSC  = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'h8;
  localparam logic [31:0] A_CNT  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic        rready = 1'b1;
  logic        rvalid;
  logic [31:0] rdata;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bready = 1'b1;
  logic        bvalid;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi4_lite_slave_timer dut (
    .s_axi_aclk_i    (clk),
    .s_axi_rst_i     (rst),
    .s_axi_araddr_i  (araddr),
    .s_axi_arvalid_i (arvalid),
    .s_axi_arready_o (arready),
    .s_axi_rready_i  (rready),
    .s_axi_rvalid_o  (rvalid),
    .s_axi_rdata_o   (rdata),
    .s_axi_awaddr_i  (awaddr),
    .s_axi_awvalid_i (awvalid),
    .s_axi_awready_o (awready),
    .s_axi_wdata_i   (wdata),
    .s_axi_wstrb_i   (wstrb),
    .s_axi_wvalid_i  (wvalid),
    .s_axi_wready_o  (wready),
    .s_axi_bready_i  (bready),
    .s_axi_bvalid_o  (bvalid),
    .irq_o           (irq)
  );

  task automatic do_reset();
    rst = 1'b1; arvalid = 0; awvalid = 0; wvalid = 0; rready = 1; bready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Write occupying exactly three clock edges: accept, apply, response.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
    if (!awready) begin
      $display("FAIL wr_accept_timeout addr=%h awready=%b required=1", a, awready);
      n_fail++; n_checks++;
    end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!bvalid) begin
      $display("FAIL wr_resp_timeout addr=%h bvalid=%b required=1", a, bvalid);
      n_fail++; n_checks++;
    end
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
    if (!arready) begin
      $display("FAIL rd_accept_timeout addr=%h arready=%b required=1", a, arready);
      n_fail++; n_checks++;
    end
    @(posedge clk); #1; arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clk); #1; n++; end
    if (!rvalid) begin
      $display("FAIL rd_data_timeout addr=%h rvalid=%b required=1", a, rvalid);
      n_fail++; n_checks++;
    end
    d = rdata;
    @(posedge clk); #1;
  endtask

  // Enable for exactly 3+k clock edges, then write the off value.
  task automatic run_en(input logic [31:0] on, input logic [31:0] off, input int k);
    axi_write(A_CTRL, on, 4'hF);
    repeat (k) begin @(posedge clk); #1; end
    axi_write(A_CTRL, off, 4'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    if ({arready, rvalid, awready, wready, bvalid, irq, rdata} !== 38'd0) begin
      $display("FAIL reset_outputs got=%b,%b,%b,%b,%b,%b,%h required=all 0",
               arready, rvalid, awready, wready, bvalid, irq, rdata);
      n_fail++;
    end
    n_checks++;
    for (int i = 0; i < 4; i++) begin
      axi_read(BASE + 32'(4 * i), d);
      if (d !== 32'd0) begin
        $display("FAIL reset_reg%0d got=%h required=00000000", i, d); n_fail++;
      end
      n_checks++;
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    do_reset();
    axi_write(A_PSC, 32'd3, 4'hF);
    axi_write(A_CMP, 32'd5, 4'hF);
    run_en(32'h1, 32'h0, 1);                 // 4 enabled edges
    axi_read(A_CNT, d);
    if (d !== 32'd1) begin $display("FAIL psc_count4 got=%0d required=1", d); n_fail++; end
    n_checks++;
    run_en(32'h1, 32'h0, 16);                // 23 total
    axi_read(A_CNT, d);
    if (d !== 32'd5) begin $display("FAIL psc_count23 got=%0d required=5", d); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'h0) begin $display("FAIL psc_nomatch23 got=%h required=0", d); n_fail++; end
    n_checks++;
    run_en(32'h1, 32'h0, 0);                 // 26 total, match at 24
    axi_read(A_CNT, d);
    if (d !== 32'd6) begin $display("FAIL psc_count26 got=%0d required=6", d); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'h8) begin $display("FAIL psc_match got=%h required=8", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_autoclr();
    logic [31:0] d;
    do_reset();
    axi_write(A_CMP, 32'd2, 4'hF);
    run_en(32'h3, 32'h2, 0);                 // 1,2,0
    axi_read(A_CNT, d);
    if (d !== 32'd0) begin $display("FAIL ac_count3 got=%0d required=0", d); n_fail++; end
    n_checks++;
    run_en(32'h3, 32'h2, 1);                 // 1,2,0,1
    axi_read(A_CNT, d);
    if (d !== 32'd1) begin $display("FAIL ac_count7 got=%0d required=1", d); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'hA) begin $display("FAIL ac_sticky got=%h required=a", d); n_fail++; end
    n_checks++;
    axi_write(A_CTRL, 32'hA, 4'hF);
    axi_read(A_CTRL, d);
    if (d !== 32'h2) begin $display("FAIL ac_w1c got=%h required=2", d); n_fail++; end
    n_checks++;
    axi_write(A_CNT, 32'd0, 4'hF);
    run_en(32'h3, 32'h2, 2);                 // 1,2,0,1,2
    axi_read(A_CNT, d);
    if (d !== 32'd2) begin $display("FAIL ac_count5 got=%0d required=2", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_miss();
    logic [31:0] d;
    int bad;
    do_reset();
    araddr = BASE + 32'h10; arvalid = 1;
    awaddr = BASE + 32'h10; wdata = 32'hF; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if ({arready, rvalid, awready, wready, bvalid} !== 5'd0) bad++;
    end
    arvalid = 0; awvalid = 0; wvalid = 0;
    if (bad != 0) begin $display("FAIL miss_handshake cycles_active=%0d required=0", bad); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'h0) begin $display("FAIL miss_no_write got=%h required=0", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_strobe();
    logic [31:0] d;
    do_reset();
    axi_write(A_CMP, 32'hAABBCCDD, 4'b0101);
    axi_read(A_CMP, d);
    if (d !== 32'h00BB00DD) begin $display("FAIL strobe got=%h required=00bb00dd", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_read_latency();
    logic [31:0] d;
    logic ok;
    do_reset();
    axi_write(A_CMP, 32'h12345678, 4'hF);
    rready = 0; araddr = A_CMP; arvalid = 1;
    @(posedge clk); #1;
    if ({arready, rvalid} !== 2'b10) begin
      $display("FAIL rlat_n1 arready,rvalid=%b%b required=10", arready, rvalid); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1; arvalid = 0;
    if ({arready, rvalid} !== 2'b01 || rdata !== 32'h12345678) begin
      $display("FAIL rlat_n2 arready,rvalid=%b%b rdata=%h required=01 12345678", arready, rvalid, rdata);
      n_fail++;
    end
    n_checks++;
    ok = 1;
    repeat (3) begin @(posedge clk); #1; if (!rvalid || rdata !== 32'h12345678) ok = 0; end
    if (!ok) begin $display("FAIL rlat_hold rvalid=%b rdata=%h required=1 12345678", rvalid, rdata); n_fail++; end
    n_checks++;
    rready = 1;
    @(posedge clk); #1;
    if (rvalid !== 1'b0) begin $display("FAIL rlat_release rvalid=%b required=0", rvalid); n_fail++; end
    n_checks++;
    axi_read(A_CMP, d);
  endtask

  task automatic test_staggered_write();
    logic [31:0] d;
    int early;
    do_reset();
    awaddr = A_PSC; wdata = 32'hFFFF1234; wstrb = 4'hF; awvalid = 1; bready = 0;
    early = 0;
    repeat (3) begin @(posedge clk); #1; if (awready || wready) early++; end
    wvalid = 1;
    if (early != 0) begin $display("FAIL stag_early_accept cycles=%0d required=0", early); n_fail++; end
    n_checks++;
    @(posedge clk); #1;
    if ({awready, wready} !== 2'b11) begin
      $display("FAIL stag_accept awready,wready=%b%b required=11", awready, wready); n_fail++;
    end
    n_checks++;
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    early = 0;
    repeat (5) begin if (!bvalid) early++; @(posedge clk); #1; end
    if (early != 0 || bvalid !== 1'b1) begin
      $display("FAIL stag_bhold low_cycles=%0d bvalid=%b required=0 1", early, bvalid); n_fail++;
    end
    n_checks++;
    bready = 1;
    @(posedge clk); #1;
    if (bvalid !== 1'b0) begin $display("FAIL stag_brelease bvalid=%b required=0", bvalid); n_fail++; end
    n_checks++;
    axi_read(A_PSC, d);
    if (d !== 32'h00001234) begin $display("FAIL stag_psc got=%h required=00001234", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_count_write_wins();
    logic [31:0] d;
    do_reset();
    axi_write(A_CMP, 32'hFFFFFFFF, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (2) begin @(posedge clk); #1; end
    axi_write(A_CNT, 32'd100, 4'hF);        // lands on a tick edge
    axi_write(A_CTRL, 32'h0, 4'hF);         // 3 more enabled edges
    axi_read(A_CNT, d);
    if (d !== 32'd103) begin $display("FAIL cnt_write_wins got=%0d required=103", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reset_midflight();
    logic [31:0] d;
    do_reset();
    rready = 0; bready = 0;
    araddr = A_CTRL; arvalid = 1;
    awaddr = A_CMP; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    repeat (2) begin @(posedge clk); #1; end
    arvalid = 0; awvalid = 0; wvalid = 0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; rready = 1; bready = 1;
    if ({rvalid, bvalid} !== 2'b00) begin
      $display("FAIL rst_mid rvalid,bvalid=%b%b required=00", rvalid, bvalid); n_fail++;
    end
    n_checks++;
    axi_read(A_CMP, d);
    if (d !== 32'h0) begin $display("FAIL rst_mid_reg got=%h required=0", d); n_fail++; end
    n_checks++;
  endtask

  task automatic test_irq();
    logic [31:0] d;
    do_reset();
`ifdef AXI4_LITE_TIMER_IRQ_EN
    axi_write(A_CTRL, 32'h7, 4'hF);         // match sets on last edge of this write
    if (irq !== 1'b0) begin $display("FAIL irq_delay irq=%b required=0", irq); n_fail++; end
    n_checks++;
    @(posedge clk); #1;
    if (irq !== 1'b1) begin $display("FAIL irq_rise irq=%b required=1", irq); n_fail++; end
    n_checks++;
    axi_write(A_CTRL, 32'hF, 4'hF);         // W1C against a re-match every tick
    if (irq !== 1'b1) begin $display("FAIL irq_set_wins irq=%b required=1", irq); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'hF) begin $display("FAIL irq_ctrl got=%h required=f", d); n_fail++; end
    n_checks++;
`else
    axi_write(A_CTRL, 32'h7, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    if (irq !== 1'b0) begin $display("FAIL irq_tied irq=%b required=0", irq); n_fail++; end
    n_checks++;
    axi_read(A_CTRL, d);
    if (d !== 32'hB) begin $display("FAIL irq_en_ignored got=%h required=b", d); n_fail++; end
    n_checks++;
`endif
    axi_write(A_CTRL, 32'h0, 4'hF);
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_autoclr();
    test_miss();
    test_strobe();
    test_read_latency();
    test_staggered_write();
    test_count_write_wins();
    test_reset_midflight();
    test_irq();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
